lsu_byte_sequencer: RTL and testbench

Load/store sequencer between the CPU memory stage and the L1 data cache. The cache accepts one byte per transaction, so this block breaks each byte, halfword or word load/store into sequential byte transactions. It holds each transaction until the cache signals ready. For loads it assembles the returned bytes little-endian and sign- or zero-extends the result. It stalls the pipeline until the whole access completes.

---
 rtl/lsu_byte_sequencer.sv | 113 +++++++++++
 tb/tb_lsu_byte_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_byte_sequencer.sv
// Load/store byte sequencer: splits CPU byte/half/word accesses into single-byte
// cache transactions, assembling load bytes little-endian and extending the result.
module lsu_byte_sequencer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  input  logic              req_wen_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              stall_o,
  output logic              resp_valid_o,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic              cache_valid_o,
  output logic              cache_wen_o,
  output logic [ADDR_W-1:0] cache_addr_o,
  output logic [7:0]        cache_wdata_o,
  input  logic              cache_ready_i,
  input  logic [7:0]        cache_rdata_i
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]        state;
  logic [1:0]        k;
  logic [1:0]        last;
  logic              wen;
  logic              uns;
  logic [ADDR_W-1:0] base_addr;
  logic [DATA_W-1:0] store_data;
  logic [DATA_W-1:0] assembly;
  logic              in_access;
  logic              in_done;

  // Extend the assembled value from its top valid byte (last = N-1).
  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] a,
                                               input logic [1:0] n_last,
                                               input logic is_uns);
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    sb = a[7:0];
    sh = a[15:0];
    case (n_last)
      2'd0:    extend = is_uns ? {24'b0, a[7:0]}  : DATA_W'(sb);
      2'd1:    extend = is_uns ? {16'b0, a[15:0]} : DATA_W'(sh);
      default: extend = a;
    endcase
  endfunction

  function automatic logic [1:0] size_to_last(input logic [1:0] size);
    case (size)
      2'b00:   size_to_last = 2'd0;
      2'b01:   size_to_last = 2'd1;
      default: size_to_last = 2'd3;
    endcase
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      k        <= 2'd0;
      assembly <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            state    <= ACCESS;
            k        <= 2'd0;
            assembly <= '0;
          end
        end
        ACCESS: begin
          if (cache_ready_i) begin
            if (!wen) assembly[{k, 3'b000} +: 8] <= cache_rdata_i;
            if (k == last) state <= DONE;
            else           k     <= k + 2'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Request attributes are only observed while ACCESS/DONE gate them, so no reset.
  always_ff @(posedge clk_i) begin
    if (state == IDLE && req_valid_i) begin
      wen        <= req_wen_i;
      uns        <= req_unsigned_i;
      last       <= size_to_last(req_size_i);
      base_addr  <= req_addr_i;
      store_data <= req_wdata_i;
    end
  end

  assign in_access = (state == ACCESS);
  assign in_done   = (state == DONE);

  assign stall_o       = (state == IDLE && req_valid_i) || in_access;
  assign cache_valid_o = in_access;
  assign cache_wen_o   = in_access && wen;
  assign cache_addr_o  = in_access ? base_addr + ADDR_W'(k) : '0;
  assign cache_wdata_o = in_access ? store_data[{k, 3'b000} +: 8] : 8'h00;
  assign resp_valid_o  = in_done;
  assign resp_rdata_o  = (in_done && !wen) ? extend(assembly, last, uns) : '0;

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// Bench for lsu_byte_sequencer: table of accesses driven through a cycle-accurate
// cache model, with per-byte and response scoreboards, plus reset/back-to-back cases.
module tb_lsu_byte_sequencer;

  typedef struct {
    logic        wen;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rbytes;
    logic [31:0] exp;
    logic [3:0][3:0] stl;
  } vec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [7:0]  data;
  } xact_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_wen_i = 1'b0;
  logic [1:0]  req_size_i = 2'b00;
  logic        req_unsigned_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        stall_o;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        cache_valid_o;
  logic        cache_wen_o;
  logic [31:0] cache_addr_o;
  logic [7:0]  cache_wdata_o;
  logic        cache_ready_i = 1'b0;
  logic [7:0]  cache_rdata_i = 8'h00;

  int n_checks = 0;
  int n_fail = 0;
  xact_t       exp_q[$];
  logic [31:0] resp_q[$];
  vec_t        vecs[9];

  lsu_byte_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_wen_i(req_wen_i), .req_size_i(req_size_i),
    .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .stall_o(stall_o), .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o),
    .cache_valid_o(cache_valid_o), .cache_wen_o(cache_wen_o), .cache_addr_o(cache_addr_o),
    .cache_wdata_o(cache_wdata_o), .cache_ready_i(cache_ready_i), .cache_rdata_i(cache_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic wen, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rbytes, input logic [31:0] exp,
                              input logic [15:0] stl);
    vec_t v;
    v.wen = wen; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.rbytes = rbytes; v.exp = exp; v.stl = stl;
    return v;
  endfunction

  task automatic drive_req(input vec_t v);
    req_valid_i    = 1'b1;
    req_wen_i      = v.wen;
    req_size_i     = v.size;
    req_unsigned_i = v.uns;
    req_addr_i     = v.addr;
    req_wdata_i    = v.wdata;
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge while the DUT is in IDLE.
  task automatic access(input vec_t v, input bit chain, input vec_t nv);
    int n, cyc, stalls;
    xact_t x;
    chk("idle_cache_valid", cache_valid_o, 0);
    chk("idle_resp_valid", resp_valid_o, 0);
    drive_req(v);
    #1;
    chk("accept_stall", stall_o, 1);
    n = (v.size == 2'b00) ? 1 : (v.size == 2'b01) ? 2 : 4;
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      x.addr = v.addr + 32'(i);
      x.wen  = v.wen;
      x.data = v.wdata[8*i +: 8];
      exp_q.push_back(x);
      stalls += int'(v.stl[i]);
    end
    resp_q.push_back(v.exp);
    step();
    cyc = 1;
    if (chain) drive_req(nv);
    else begin
      req_valid_i = 1'b0;
      req_addr_i  = $urandom;
      req_wdata_i = $urandom;
    end
    for (int b = 0; b < n; b++) begin
      for (int s = 0; s <= int'(v.stl[b]); s++) begin
        cache_ready_i = (s == int'(v.stl[b]));
        cache_rdata_i = cache_ready_i ? v.rbytes[8*b +: 8] : 8'($urandom);
        #1;
        x = exp_q[0];
        chk("byte_valid", cache_valid_o, 1);
        chk("byte_stall", stall_o, 1);
        chk("byte_addr", cache_addr_o, x.addr);
        chk("byte_wen", cache_wen_o, x.wen);
        chk("byte_wdata", cache_wdata_o, x.data);
        chk("byte_resp_idle", resp_valid_o, 0);
        step();
        cyc++;
      end
      void'(exp_q.pop_front());
    end
    cache_ready_i = 1'b1;
    cache_rdata_i = 8'hFF;
    #1;
    chk("done_resp_valid", resp_valid_o, 1);
    chk("done_stall", stall_o, 0);
    chk("done_cache_valid", cache_valid_o, 0);
    chk("done_rdata", resp_rdata_o, resp_q.pop_front());
    chk("done_latency", 32'(cyc), 32'(n + stalls + 1));
    step();
    cache_ready_i = 1'b0;
    if (!chain) begin
      #1;
      chk("after_resp_valid", resp_valid_o, 0);
      chk("after_stall", stall_o, 0);
    end
  endtask

  initial begin
    vec_t dummy, sw;
    dummy = mk(0, 2'b00, 0, 0, 0, 0, 0, 16'h0);
    //            wen size   uns addr          wdata         rbytes        expected      stalls
    vecs[0] = mk(0, 2'b00, 0, 32'h0000_0100, 32'h0,        32'h0000_0080, 32'hFFFF_FF80, 16'h0000);
    vecs[1] = mk(0, 2'b01, 1, 32'h0000_0202, 32'h0,        32'h0000_1234, 32'h0000_1234, 16'h0010);
    vecs[2] = mk(1, 2'b10, 0, 32'h0000_0300, 32'hDEAD_BEEF, 32'h5A5A_5A5A, 32'h0,        16'h0005);
    vecs[3] = mk(0, 2'b10, 0, 32'hFFFF_FFFE, 32'h0,        32'h1234_5678, 32'h1234_5678, 16'h0000);
    vecs[4] = mk(0, 2'b00, 1, 32'h0000_0007, 32'h0,        32'h0000_00F0, 32'h0000_00F0, 16'h0002);
    vecs[5] = mk(0, 2'b01, 0, 32'h0000_0011, 32'h0,        32'h0000_9001, 32'hFFFF_9001, 16'h0000);
    vecs[6] = mk(1, 2'b00, 0, 32'h0000_0020, 32'hAABB_CCDD, 32'h0000_0077, 32'h0,        16'h0000);
    vecs[7] = mk(0, 2'b11, 0, 32'h0000_0040, 32'h0,        32'h8433_2211, 32'h8433_2211, 16'h1020);
    vecs[8] = mk(1, 2'b01, 0, 32'hFFFF_FFFF, 32'h0000_CAFE, 32'h0,        32'h0,        16'h0100);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    chk("rst_stall", stall_o, 0);
    chk("rst_resp_valid", resp_valid_o, 0);
    chk("rst_resp_rdata", resp_rdata_o, 0);
    chk("rst_cache_valid", cache_valid_o, 0);
    chk("rst_cache_wen", cache_wen_o, 0);
    chk("rst_cache_addr", cache_addr_o, 0);
    chk("rst_cache_wdata", cache_wdata_o, 0);
    step();

    for (int i = 0; i < 9; i++) access(vecs[i], 1'b0, dummy);

    // Back-to-back: LB then an LW held on req_valid_i throughout.
    access(vecs[0], 1'b1, vecs[3]);
    access(vecs[3], 1'b0, dummy);

    // Reset during byte 2 of a word store, with ready asserted the same cycle.
    sw = mk(1, 2'b10, 0, 32'h0000_0400, 32'h1122_3344, 32'h0, 32'h0, 16'h0);
    drive_req(sw);
    step();
    req_valid_i = 1'b0;
    for (int b = 0; b < 2; b++) begin
      cache_ready_i = 1'b1;
      #1;
      chk("rst_seq_addr", cache_addr_o, 32'h0000_0400 + 32'(b));
      step();
    end
    #1;
    chk("rst_seq_b2_addr", cache_addr_o, 32'h0000_0402);
    chk("rst_seq_b2_wdata", cache_wdata_o, 32'h22);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    cache_ready_i = 1'b0;
    #1;
    chk("rst_seq_cache_valid", cache_valid_o, 0);
    chk("rst_seq_resp_valid", resp_valid_o, 0);
    chk("rst_seq_stall", stall_o, 0);
    chk("rst_seq_cache_addr", cache_addr_o, 0);
    step();
    chk("rst_seq_resp_later", resp_valid_o, 0);
    access(vecs[0], 1'b0, dummy);

    chk("xact_queue_empty", 32'(exp_q.size()), 0);
    chk("resp_queue_empty", 32'(resp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
